// File: rtl/fib_gen.sv
// rtl/fib_gen.sv - Fibonacci-style term generator with single and streaming output modes
module fib_gen #(
  parameter int W  = 16,
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          stream,
  input  logic [NW-1:0] n,
  input  logic [W-1:0]  seed0,
  input  logic [W-1:0]  seed1,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  output logic [W-1:0]  f,
  output logic [NW-1:0] idx,
  output logic          ovf
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [NW-1:0] n_q;          // index of the final term for this run
  logic [NW-1:0] k_q;          // index of the next term to load
  logic [W-1:0]  t_cur;        // T(k_q)
  logic [W-1:0]  t_nxt;        // T(k_q+1)
  logic          c_cur;        // T(k_q) wrapped when it was formed
  logic          c_nxt;        // T(k_q+1) wrapped when it was formed
  logic          stream_q;
  logic          last_loaded;  // term n already sits in f (stream mode)
  logic [W:0]    sum;
  logic          accept;
  logic          slot_free;
  logic          step;

  assign sum = {1'b0, t_cur} + {1'b0, t_nxt};

  // Decide whether this edge loads a new term and whether a held term is taken.
  always_comb begin
    accept    = out_valid & out_ready;
    slot_free = !stream_q || !out_valid || out_ready;
    step      = (state == S_RUN) && !pause && !abort && slot_free && !last_loaded;
  end

  // Run control, term pipeline and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      f           <= '0;
      idx         <= '0;
      ovf         <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      t_cur       <= '0;
      t_nxt       <= '0;
      c_cur       <= 1'b0;
      c_nxt       <= 1'b0;
      stream_q    <= 1'b0;
      last_loaded <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !pause && !abort) begin
            n_q         <= n;
            stream_q    <= stream;
            t_cur       <= seed0;
            t_nxt       <= seed1;
            c_cur       <= 1'b0;
            c_nxt       <= 1'b0;
            k_q         <= '0;
            last_loaded <= 1'b0;
            ovf         <= 1'b0;
            f           <= '0;
            busy        <= 1'b1;
            state       <= S_RUN;
          end
        end
        default: begin
          if (abort) begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end else if (stream_q && accept && last_loaded) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end else if (step) begin
            f     <= t_cur;
            idx   <= k_q;
            ovf   <= ovf | c_cur;
            t_cur <= t_nxt;
            c_cur <= c_nxt;
            t_nxt <= sum[W-1:0];
            c_nxt <= sum[W];
            k_q   <= k_q + 1'b1;
            if (stream_q) begin
              out_valid <= 1'b1;
              if (k_q == n_q) last_loaded <= 1'b1;
            end else if (k_q == n_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end else if (accept) begin
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_gen.sv
// tb/tb_fib_gen.sv - randomized self-checking bench for fib_gen against an arithmetic model
module tb_fib_gen;

  logic        clk;
  logic        rst_n;
  logic        start, pause, abort, stream_in, out_ready;
  logic [4:0]  n_in;
  logic [15:0] seed0_in, seed1_in;

  logic        busy16, done16, out_valid16, ovf16;
  logic [15:0] f16;
  logic [4:0]  idx16;
  logic        busy8, done8, out_valid8, ovf8;
  logic [7:0]  f8;
  logic [4:0]  idx8;

  int tests = 0;
  int fails = 0;

  fib_gen #(.W(16), .NW(5)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .stream(stream_in), .n(n_in), .seed0(seed0_in), .seed1(seed1_in),
    .out_ready(out_ready), .busy(busy16), .done(done16), .out_valid(out_valid16),
    .f(f16), .idx(idx16), .ovf(ovf16)
  );

  fib_gen #(.W(8), .NW(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .stream(stream_in), .n(n_in), .seed0(seed0_in[7:0]), .seed1(seed1_in[7:0]),
    .out_ready(out_ready), .busy(busy8), .done(done8), .out_valid(out_valid8),
    .f(f8), .idx(idx8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // T(k) mod 2^w and whether any of T(2..k) wrapped.
  function automatic void fib_ref(input int w, input int s0, input int s1, input int k,
                                  output int t, output int ov);
    int mask, a, b, s;
    mask = (1 << w) - 1;
    a = s0 & mask;
    b = s1 & mask;
    ov = 0;
    if (k == 0) t = a;
    else begin
      for (int i = 2; i <= k; i++) begin
        s = a + b;
        if (s > mask) ov = 1;
        a = b;
        b = s & mask;
      end
      t = b;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input int s0, input int s1, input int nn,
                            input bit use_pause, input bit hold_start);
    int lat, pcnt, t, ov;
    logic [15:0] pf;
    logic [4:0]  pi;
    n_in = nn[4:0]; seed0_in = s0[15:0]; seed1_in = s1[15:0];
    stream_in = 1'b0; out_ready = 1'b0; start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    check("sg_busy_on", 32'(busy16), 32'd1);
    lat = 0; pcnt = 0;
    while (!done16 && lat < 300) begin
      pause = use_pause && ($urandom_range(0, 3) == 0);
      if (pause) pcnt++;
      pf = f16; pi = idx16;
      tick();
      lat++;
      if (pause) begin
        check("sg_frz_f", 32'(f16), 32'(pf));
        check("sg_frz_idx", 32'(idx16), 32'(pi));
      end
      pause = 1'b0;
    end
    start = 1'b0;
    check("sg_latency", 32'(lat), 32'(nn + 1 + pcnt));
    check("sg_done16", 32'(done16), 32'd1);
    check("sg_done8", 32'(done8), 32'd1);
    check("sg_busy_off", 32'(busy16), 32'd0);
    fib_ref(16, s0, s1, nn, t, ov);
    check("sg_f16", 32'(f16), 32'(t));
    check("sg_ovf16", 32'(ovf16), 32'(ov));
    check("sg_idx16", 32'(idx16), 32'(nn));
    fib_ref(8, s0, s1, nn, t, ov);
    check("sg_f8", 32'(f8), 32'(t));
    check("sg_ovf8", 32'(ovf8), 32'(ov));
    check("sg_idx8", 32'(idx8), 32'(nn));
    tick();
    check("sg_done_pulse", 32'(done16), 32'd0);
    check("sg_no_restart", 32'(busy16), 32'd0);
  endtask

  // mode 0: always ready; 1: random ready and pause; 2: stall 3 cycles at idx 2
  task automatic run_stream(input int s0, input int s1, input int nn, input int mode);
    int exp_k, edges, stall, t, ov;
    bit held;
    logic [15:0] hf;
    logic [4:0]  hi;
    n_in = nn[4:0]; seed0_in = s0[15:0]; seed1_in = s1[15:0];
    stream_in = 1'b1; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    stream_in = 1'b0;
    exp_k = 0; edges = 0; stall = 0;
    while (!done16 && edges < 400) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = $urandom_range(0, 1) == 1;
        default: begin
          out_ready = !(out_valid16 && idx16 == 5'd2 && stall < 3);
          if (!out_ready) stall++;
        end
      endcase
      pause = (mode == 1) && ($urandom_range(0, 4) == 0);
      if (out_valid16 && out_ready) begin
        check("st_idx", 32'(idx16), 32'(exp_k));
        fib_ref(16, s0, s1, exp_k, t, ov);
        check("st_f16", 32'(f16), 32'(t));
        check("st_ovf16", 32'(ovf16), 32'(ov));
        fib_ref(8, s0, s1, exp_k, t, ov);
        check("st_f8", 32'(f8), 32'(t));
        check("st_ovf8", 32'(ovf8), 32'(ov));
        exp_k++;
      end
      held = out_valid16 && !out_ready;
      hf = f16; hi = idx16;
      tick();
      edges++;
      if (held) begin
        check("st_hold_f", 32'(f16), 32'(hf));
        check("st_hold_idx", 32'(idx16), 32'(hi));
        check("st_hold_valid", 32'(out_valid16), 32'd1);
      end
    end
    out_ready = 1'b0; pause = 1'b0;
    check("st_done", 32'(done16), 32'd1);
    check("st_count", 32'(exp_k), 32'(nn + 1));
    check("st_busy_off", 32'(busy16), 32'd0);
    check("st_valid_off", 32'(out_valid16), 32'd0);
    if (mode == 0) check("st_edges", 32'(edges), 32'(nn + 2));
    if (mode == 2) check("st_edges_stall", 32'(edges), 32'(nn + 5));
    tick();
    check("st_done_pulse", 32'(done16), 32'd0);
  endtask

  initial begin
    int seen;
    logic [15:0] hf;
    logic [4:0]  hi;
    logic        ho;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; stream_in = 1'b0;
    out_ready = 1'b0; n_in = '0; seed0_in = '0; seed1_in = '0;
    tick(); tick();
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_done", 32'(done16), 32'd0);
    check("rst_valid", 32'(out_valid16), 32'd0);
    check("rst_f", 32'(f16), 32'd0);
    check("rst_idx", 32'(idx16), 32'd0);
    check("rst_ovf", 32'(ovf16), 32'd0);
    rst_n = 1'b1;
    tick();

    run_single(0, 1, 10, 0, 0);
    run_single(0, 1, 13, 0, 0);
    run_single(0, 1, 14, 0, 0);
    run_single(9, 4, 0, 0, 0);
    run_single(9, 4, 6, 0, 1);
    for (int r = 0; r < 10; r++)
      run_single(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 31)), 1, 0);

    run_stream(2, 1, 5, 0);
    run_stream(0, 1, 8, 2);
    run_stream(9, 4, 0, 0);
    for (int r = 0; r < 10; r++)
      run_stream(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 31)), 1);

    // start ignored while pause or abort is high in idle
    start = 1'b1; pause = 1'b1;
    tick();
    check("idle_pause_ign", 32'(busy16), 32'd0);
    pause = 1'b0; abort = 1'b1;
    tick();
    check("idle_abort_ign", 32'(busy16), 32'd0);
    start = 1'b0; abort = 1'b0;

    // abort mid-run, also with pause high
    n_in = 5'd20; seed0_in = 16'd3; seed1_in = 16'd5; stream_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    hf = f16; hi = idx16; ho = ovf16;
    abort = 1'b1; pause = 1'b1;
    tick();
    abort = 1'b0; pause = 1'b0;
    check("ab_busy", 32'(busy16), 32'd0);
    check("ab_done", 32'(done16), 32'd0);
    check("ab_valid", 32'(out_valid16), 32'd0);
    check("ab_f_hold", 32'(f16), 32'(hf));
    check("ab_idx_hold", 32'(idx16), 32'(hi));
    check("ab_ovf_hold", 32'(ovf16), 32'(ho));
    seen = 0;
    repeat (30) begin
      tick();
      if (done16 || busy16) seen++;
    end
    check("ab_no_done", 32'(seen), 32'd0);

    // asynchronous reset mid-run
    n_in = 5'd25; seed0_in = 16'd7; seed1_in = 16'd9; stream_in = 1'b1; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; stream_in = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(busy16), 32'd0);
    check("ar_valid", 32'(out_valid16), 32'd0);
    check("ar_f", 32'(f16), 32'd0);
    check("ar_idx", 32'(idx16), 32'd0);
    check("ar_ovf", 32'(ovf16), 32'd0);
    check("ar_done", 32'(done16), 32'd0);
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (done16 || busy16) seen++;
    end
    check("ar_no_done", 32'(seen), 32'd0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
